// File: rtl/mux_nx1_stream_pkg.sv
// Shared definitions for the N-to-1 streaming mux family: default widths,
// lane-count helper and the arbitration mode encoding.
package mux_nx1_stream_pkg;

   localparam int LEN_DEF   = 8;
   localparam int SEL_W_DEF = 2;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mode_e;

   // Number of lanes addressed by a select field of the given width.
   function automatic int lanes(input int sel_w);
      return int'(32'd1 << sel_w);
   endfunction

endpackage

// File: rtl/mux_nx1_stream_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting lane after ptr, wrapping
// from the last lane back to lane 0. Purely combinational.
module rr_arbiter
   import mux_nx1_stream_pkg::*;
#(
   parameter  int SEL_W  = SEL_W_DEF,
   localparam int NUM_IN = lanes(SEL_W)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic [NUM_IN-1:0] grant,
   output logic [SEL_W-1:0]  idx,
   output logic              any
);

   logic [NUM_IN-1:0] grant_s;
   logic [SEL_W-1:0]  idx_s;

   // Search ptr+1 .. ptr+NUM_IN; the SEL_W-bit add wraps modulo NUM_IN.
   always_comb begin
      logic [SEL_W-1:0] lane_s;
      logic             hit_s;
      logic             found_s;
      grant_s = {NUM_IN{1'b0}};
      idx_s   = {SEL_W{1'b0}};
      lane_s  = {SEL_W{1'b0}};
      hit_s   = 1'b0;
      found_s = 1'b0;
      for (int k = 1; k <= NUM_IN; k++) begin
         lane_s          = ptr + SEL_W'(k);
         hit_s           = req[lane_s] & ~found_s;
         grant_s[lane_s] = hit_s;
         idx_s           = hit_s ? lane_s : idx_s;
         found_s         = found_s | req[lane_s];
      end
   end

   assign grant = grant_s;
   assign idx   = idx_s;
   assign any   = |req;

endmodule

// File: rtl/mux_nx1_stream.sv
// N-to-1 streaming multiplexer with valid/ready handshakes, a registered
// output stage and runtime choice between fixed select and round-robin.
module mux_nx1_stream
   import mux_nx1_stream_pkg::*;
#(
   parameter  int LEN    = LEN_DEF,
   parameter  int SEL_W  = SEL_W_DEF,
   localparam int NUM_IN = lanes(SEL_W)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_IN*LEN-1:0] in_data,
   input  logic [NUM_IN-1:0]     in_valid,
   output logic [NUM_IN-1:0]     in_ready,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  rr_en,
   output logic [LEN-1:0]        out_data,
   output logic [SEL_W-1:0]      out_src,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [NUM_IN-1:0] arb_grant_s;
   logic [SEL_W-1:0]  arb_idx_s;
   logic              arb_any_s;
   logic [NUM_IN-1:0] grant_s;
   logic [SEL_W-1:0]  src_s;
   logic              load_s;
   logic              xfer_s;
   mode_e             mode_s;

   logic [LEN-1:0]    out_data_r;
   logic [SEL_W-1:0]  out_src_r;
   logic              out_valid_r;
   logic [SEL_W-1:0]  rr_ptr_r;

   rr_arbiter #(.SEL_W(SEL_W)) u_arb (
      .req   (in_valid),
      .ptr   (rr_ptr_r),
      .grant (arb_grant_s),
      .idx   (arb_idx_s),
      .any   (arb_any_s)
   );

   assign mode_s = mode_e'(rr_en);

   // Grant selection: arbiter result in round-robin mode, else the selected lane only.
   always_comb begin
      grant_s = {NUM_IN{1'b0}};
      src_s   = sel;
      case (mode_s)
         MODE_RR: begin
            grant_s = arb_grant_s;
            src_s   = arb_idx_s;
         end
         MODE_SEL: begin
            grant_s[sel] = in_valid[sel];
            src_s        = sel;
         end
         default: begin
            grant_s = {NUM_IN{1'b0}};
            src_s   = sel;
         end
      endcase
   end

   // The output register accepts a word when empty or draining this cycle.
   assign load_s   = ~out_valid_r | out_ready;
   assign in_ready = grant_s & {NUM_IN{load_s}};
   assign xfer_s   = |(in_ready & in_valid);

   // Output stage and round-robin pointer; a reset drops any held word.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {LEN{1'b0}};
         out_src_r   <= {SEL_W{1'b0}};
         rr_ptr_r    <= {SEL_W{1'b1}};
      end else if (xfer_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= in_data[int'(src_s)*LEN +: LEN];
         out_src_r   <= src_s;
         if (mode_s == MODE_RR) begin
            rr_ptr_r <= src_s;
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign out_data  = out_data_r;
   assign out_src   = out_src_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed self-checking bench for mux_nx1_stream (LEN=8, 4 lanes).
module tb_mux_nx1_stream;

   localparam int LEN   = 8;
   localparam int SEL_W = 2;
   localparam int N     = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [N*LEN-1:0] in_data;
   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_ready;
   logic [SEL_W-1:0] sel;
   logic             rr_en;
   logic [LEN-1:0]   out_data;
   logic [SEL_W-1:0] out_src;
   logic             out_valid;
   logic             out_ready;

   int checks = 0;
   int errors = 0;

   mux_nx1_stream #(.LEN(LEN), .SEL_W(SEL_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .rr_en     (rr_en),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [7:0] d);
      in_data[i*LEN +: LEN] = d;
   endtask

   task automatic do_reset();
      in_valid = 4'b0000;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      rr_en = 1'b1; sel = 2'd0; out_ready = 1'b1; reset = 1'b0;
      for (int i = 0; i < N; i++) set_lane(i, 8'(8'h50 + i));
      in_valid = 4'b1111;
      tick();
      tick();
      reset = 1'b1;
      in_valid = 4'b0000;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
      checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d expected 0", out_src); end
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
      reset = 1'b0;
   endtask

   task automatic test_sel_mode();
      rr_en = 1'b0; sel = 2'd2; out_ready = 1'b1;
      set_lane(0, 8'h11); set_lane(1, 8'h22); set_lane(2, 8'hA5); set_lane(3, 8'h44);
      in_valid = 4'b0100;
      #1;
      checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL sel_in_ready: got %b expected 0100", in_ready); end
      tick();
      in_valid = 4'b0000;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2) begin
         errors++; $display("FAIL sel_out: got v=%b d=%h s=%0d expected v=1 d=a5 s=2", out_valid, out_data, out_src); end
      tick();
      checks++; if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
         errors++; $display("FAIL sel_drain: got v=%b d=%h expected v=0 d=a5", out_valid, out_data); end
   endtask

   task automatic test_rr_all();
      logic [SEL_W-1:0] exp_src [5];
      exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rr_en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < N; i++) set_lane(i, 8'(8'h10 + i));
      in_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++; if (out_valid !== 1'b1 || out_src !== exp_src[c] || out_data !== 8'(8'h10 + exp_src[c])) begin
            errors++; $display("FAIL rr_all[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                               c, out_valid, out_src, out_data, exp_src[c], 8'(8'h10 + exp_src[c])); end
      end
      in_valid = 4'b0000;
      tick();
   endtask

   task automatic test_rr_sparse();
      logic [SEL_W-1:0] exp_src [3];
      logic [N-1:0]     exp_rdy [3];
      exp_src = '{2'd1, 2'd3, 2'd1};
      exp_rdy = '{4'b0010, 4'b1000, 4'b0010};
      rr_en = 1'b1; out_ready = 1'b1;
      in_valid = 4'b1010;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (in_ready !== exp_rdy[c]) begin
            errors++; $display("FAIL rr_sparse_ready[%0d]: got %b expected %b", c, in_ready, exp_rdy[c]); end
         tick();
         checks++; if (out_valid !== 1'b1 || out_src !== exp_src[c]) begin
            errors++; $display("FAIL rr_sparse_src[%0d]: got v=%b s=%0d expected v=1 s=%0d", c, out_valid, out_src, exp_src[c]); end
      end
      in_valid = 4'b0000;
      tick();
   endtask

   task automatic test_stall();
      rr_en = 1'b0; sel = 2'd0; out_ready = 1'b1;
      set_lane(0, 8'h3C);
      in_valid = 4'b0001;
      tick();
      out_ready = 1'b0;
      set_lane(0, 8'h4D); set_lane(3, 8'h77);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin sel = 2'd3; in_valid = 4'b1001; rr_en = 1'b1; end
         #1;
         checks++; if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL stall_ready[%0d]: got %b expected 0000", c, in_ready); end
         tick();
         checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_src !== 2'd0) begin
            errors++; $display("FAIL stall_hold[%0d]: got v=%b d=%h s=%0d expected v=1 d=3c s=0", c, out_valid, out_data, out_src); end
      end
      rr_en = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL release_ready: got %b expected 0001", in_ready); end
      tick();
      in_valid = 4'b0000;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h4D || out_src !== 2'd0) begin
         errors++; $display("FAIL release_next: got v=%b d=%h s=%0d expected v=1 d=4d s=0", out_valid, out_data, out_src); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_sel_invalid_then_rr();
      logic [7:0]       q0 [3];
      logic [7:0]       q2 [2];
      logic [SEL_W-1:0] exp_src [5];
      logic [7:0]       exp_dat [5];
      int               h0, h2;
      q0 = '{8'h01, 8'h02, 8'h03};
      q2 = '{8'h21, 8'h22};
      exp_src = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
      exp_dat = '{8'h01, 8'h21, 8'h02, 8'h22, 8'h03};
      h0 = 0; h2 = 0;
      do_reset();
      rr_en = 1'b0; sel = 2'd1; out_ready = 1'b1;
      set_lane(0, q0[0]); set_lane(1, 8'hEE);
      in_valid = 4'b0001;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL sel_invalid_ready[%0d]: got %b expected 0000", c, in_ready); end
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sel_invalid_out[%0d]: got %b expected 0", c, out_valid); end
      end
      rr_en = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_valid[0] = (h0 < 3);
         in_valid[2] = (h2 < 2);
         if (h0 < 3) set_lane(0, q0[h0]);
         if (h2 < 2) set_lane(2, q2[h2]);
         #1;
         if (in_valid[0] && in_ready[0]) h0++;
         if (in_valid[2] && in_ready[2]) h2++;
         tick();
         checks++; if (out_valid !== 1'b1 || out_src !== exp_src[c] || out_data !== exp_dat[c]) begin
            errors++; $display("FAIL rr_order[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                               c, out_valid, out_src, out_data, exp_src[c], exp_dat[c]); end
      end
      in_valid = 4'b0000;
      tick();
      checks++; if (h0 != 3 || h2 != 2 || out_valid !== 1'b0) begin
         errors++; $display("FAIL rr_complete: got h0=%0d h2=%0d v=%b expected h0=3 h2=2 v=0", h0, h2, out_valid); end
   endtask

   initial begin
      reset = 1'b1; in_data = '0; in_valid = 4'b0000; sel = 2'd0; rr_en = 1'b0; out_ready = 1'b1;
      tick();
      reset = 1'b0;
      test_reset();
      test_sel_mode();
      test_rr_all();
      test_rr_sparse();
      test_stall();
      test_sel_invalid_then_rr();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
